uart_tx: RTL

Byte-wide UART transmitter with a small input FIFO. It serialises bytes as 8N1 frames: one start bit (0), eight data bits LSB first, one stop bit (1). Each bit lasts exactly DIVISOR clock cycles. It is the transmit partner of the UART receiver, sits between the LPC-side register logic and the serial pin, and uses the same baud setup: 286 cycles per bit at 32.9472 MHz gives 115200 baud.

---
 rtl/uart_tx_if.sv | 25 ++
 rtl/uart_tx.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-side status of the UART transmitter.
// master = byte producer, slave = transmitter.
interface uart_tx_if;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;

    modport master (
        output data,
        output data_valid,
        input  data_ready,
        input  tx,
        input  busy
    );

    modport slave (
        input  data,
        input  data_valid,
        output data_ready,
        output tx,
        output busy
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a small circular FIFO.
// Every bit (start, data LSB first, stop) lasts DIVISOR clocks; queued bytes go out back-to-back.
module uart_tx #(
    parameter int unsigned DIVISOR    = 286,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DIVISOR);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [2:0]       r_idx, w_idx_d;
    logic [7:0]       r_shift, w_shift_d;
    logic             r_tx, w_tx_d;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [PTR_W:0]   r_count;

    logic w_full, w_empty, w_push, w_pop, w_cnt_last;

    // A full FIFO refuses a push even if a pop frees a slot on the same edge.
    assign w_full     = (r_count == FIFO_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.data_valid && !w_full;
    assign w_cnt_last = (r_cnt == CNT_LAST);

    assign bus.data_ready = !w_full;
    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != StIdle) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_idx   <= w_idx_d;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_idx_d   = r_idx;
        w_shift_d = r_shift;
        w_tx_d    = r_tx;
        w_pop     = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_tx_d  = 1'b1;
                w_cnt_d = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = r_mem[r_rptr];
                    w_tx_d    = 1'b0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_cnt_last) begin
                    w_cnt_d   = '0;
                    w_tx_d    = r_shift[0];
                    w_idx_d   = '0;
                    w_state_d = StData;
                end
            end
            StData: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_cnt_last) begin
                    w_cnt_d = '0;
                    if (r_idx == 3'd7) begin
                        w_tx_d    = 1'b1;
                        w_state_d = StStop;
                    end else begin
                        w_shift_d = r_shift >> 1;
                        w_tx_d    = r_shift[1];
                        w_idx_d   = r_idx + 3'd1;
                    end
                end
            end
            StStop: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_cnt_last) begin
                    w_cnt_d = '0;
                    // Pop straight into the next start bit so queued frames have no gap.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = r_mem[r_rptr];
                        w_tx_d    = 1'b0;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end
endmodule
